event_rate_meter: RTL and testbench
===================================

// Module: event_rate_meter
// PURPOSE
//  Parametrised successor to the fixed-period frequency counter: measures event rate on N async inputs
//  (IRQ, fix_pulse, PPS, strobes) within one reference clock domain. Inputs are synchronised and edge-detected.
//  Edges are counted over a gate window whose length can be changed at run time, with per-channel edge mode.
//  Results are snapshotted with saturation/overflow flags and a valid strobe.
//  Sits beside the TRCV in the top, clocked from CLK_50; results are read through a channel-select port.
// PARAMETERS
//  CHANNELS     6           number of measured inputs (1..32)
//  CNT_WIDTH    32          width of per-channel edge counter/result
//  REF_HZ       50_000_000  clk frequency, Hz
//  PERIOD_MS    10          default gate length, ms; DEF_GATE = REF_HZ/1000*PERIOD_MS cycles
//  GATE_W       32          width of gate_len override; must hold DEF_GATE
//  SYNC_STAGES  2           synchroniser depth (>=2)
//  BOTH_EDGES   '0          per-channel bitmask: 1 = count both edges, 0 = rising only
// PORTS
//  clk       in   1                 reference clock
//  rst       in   1                 async reset, active-high
//  en        in   1                 run enable; level
//  gate_len  in   GATE_W            gate length in cycles; 0 selects DEF_GATE; sampled at window start
//  in_sig    in   CHANNELS          async inputs
//  rd_ch     in   $clog2(CHANNELS)+1 result channel select
//  rd_data   out  CNT_WIDTH         registered result of rd_ch
//  ovf       out  CHANNELS          per-channel saturation flag of last snapshot
//  valid     out  1                 one-cycle strobe: new snapshot available
//  win_cnt   out  16                completed windows since run start; wraps at 0xFFFF -> 0
//  busy      out  1                 1 while in ARM or RUN
// BEHAVIOUR
//  Reset: all flops 0; rd_data=0, ovf=0, valid=0, win_cnt=0, busy=0; FSM=IDLE; sync chains cleared.
//  Sync: SYNC_STAGES flops per channel, then a 1-flop edge detector. An edge is counted in the cycle
//   the sync output differs from its delayed copy. Latency from in_sig to count = SYNC_STAGES+1 cycles.
//  FSM states:
//   IDLE: counters held at 0. en=1 -> ARM.
//   ARM (1 cycle): clear counters; latch L = (gate_len==0 ? DEF_GATE : gate_len); gate_cnt=L-1. -> RUN.
//   RUN: gate_cnt decrements each cycle. en=0 -> IDLE: window aborted, no valid, results untouched.
//    At gate_cnt==0:
//     - Snapshot counters into result regs and flags into ovf.
//     - valid=1 next cycle; win_cnt+=1.
//     - Reload gate_cnt from a fresh gate_len sample, same 0 rule.
//     - Clear counters. No dead cycle between windows.
//  Window boundary: an edge detected in the gate_cnt==0 cycle belongs to the closing window.
//   An edge in the next cycle belongs to the new window.
//  Counters: +1 per counted edge. At all-ones: hold value, set sticky per-window ovf bit.
//   Both set bits are cleared at the window start.
//  Readout: rd_data <= result[rd_ch] every cycle (1-cycle latency); rd_ch>=CHANNELS -> 0.
//   result/ovf persist until the next snapshot or reset; valid is a pulse, never held.
//  win_cnt clears on IDLE->ARM. busy = (state!=IDLE).
//  rst asserted mid-window: immediate return to reset values, no valid. With en=1 at release: ARM on the first clk.
// TESTING
//  Params REF_HZ=1000, PERIOD_MS=10 (DEF_GATE=10), CHANNELS=4, BOTH_EDGES=4'b0010.
//  1 Rate and mode: gate_len=100, in_sig[0] and in_sig[1] = same square wave, period 4 clk.
//    -> first valid: result[0]=25, result[1]=50, ovf=0, win_cnt=1.
//  2 Default gate / override: gate_len=0, one edge per 2 clk on ch2 -> valid every 10 cycles, result[2]=5.
//    Change gate_len=20 mid-window -> next window only lasts 20 cycles.
//  3 Saturation: CNT_WIDTH=4, gate_len=100, ch3 rising edge every 2 clk -> result[3]=15, ovf[3]=1.
//    Next window with 5 edges -> result=5, ovf[3]=0.
//  4 Boundary: detected edge on gate_cnt==0 cycle counts in old window.
//    Detected edge one cycle later counts in new window. Check both by exact placement.
//  5 Abort/reset: en=0 at cycle 7 of window -> no valid, rd_data keeps old value, busy=0.
//    rst pulse in RUN -> all outputs 0; rd_ch=5 -> rd_data=0.

Source files
------------

// File: rtl/event_rate_meter.sv
// Multi-channel event rate meter: synchronised edge counters gated by a run-time
// programmable window, snapshotted into result registers with per-channel overflow.

module erm_lane #(
  parameter int CNT_WIDTH   = 32,
  parameter int SYNC_STAGES = 2,
  parameter bit BOTH        = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_sig,
  input  logic                 i_clr,
  output logic [CNT_WIDTH-1:0] o_next_cnt,
  output logic                 o_next_ovf
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_ovf;
  logic                   w_sync;
  logic                   w_edge;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_edge = BOTH ? (w_sync ^ r_dly) : (w_sync & ~r_dly);

  // Next count includes this cycle's edge so the closing window can snapshot it.
  always_comb begin
    o_next_cnt = r_cnt;
    o_next_ovf = r_ovf;
    if (w_edge) begin
      if (&r_cnt) o_next_ovf = 1'b1;
      else        o_next_cnt = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
      r_dly  <= w_sync;
      if (i_clr) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else begin
        r_cnt <= o_next_cnt;
        r_ovf <= o_next_ovf;
      end
    end
  end
endmodule

module event_rate_meter #(
  parameter int                  CHANNELS    = 6,
  parameter int                  CNT_WIDTH   = 32,
  parameter int                  REF_HZ      = 50_000_000,
  parameter int                  PERIOD_MS   = 10,
  parameter int                  GATE_W      = 32,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [CHANNELS-1:0] BOTH_EDGES  = '0,
  localparam int                 RD_W        = $clog2(CHANNELS) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [GATE_W-1:0]    gate_len,
  input  logic [CHANNELS-1:0]  in_sig,
  input  logic [RD_W-1:0]      rd_ch,
  output logic [CNT_WIDTH-1:0] rd_data,
  output logic [CHANNELS-1:0]  ovf,
  output logic                 valid,
  output logic [15:0]          win_cnt,
  output logic                 busy
);
  localparam logic [GATE_W-1:0] DEF_GATE = GATE_W'(REF_HZ / 1000 * PERIOD_MS);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} state_t;

  state_t                               r_state, w_next;
  logic [GATE_W-1:0]                    r_gate;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0]   r_result;
  logic [CHANNELS-1:0]                  r_ovf;
  logic [CNT_WIDTH-1:0]                 r_rd;
  logic                                 r_valid;
  logic [15:0]                          r_win;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0]   w_next_cnt;
  logic [CHANNELS-1:0]                  w_next_ovf;
  logic [GATE_W-1:0]                    w_gate_ld;
  logic [CNT_WIDTH-1:0]                 w_rd;
  logic                                 w_close;
  logic                                 w_start;
  logic                                 w_clr;

  assign w_gate_ld = (gate_len == '0) ? DEF_GATE : gate_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Abort on en=0 takes priority over closing the window in the same cycle.
  always_comb begin
    w_next  = r_state;
    w_close = 1'b0;
    w_start = 1'b0;
    case (r_state)
      S_IDLE: if (en) begin
        w_next  = S_ARM;
        w_start = 1'b1;
      end
      S_ARM:  w_next = S_RUN;
      S_RUN: begin
        if (!en)                 w_next  = S_IDLE;
        else if (r_gate == '0)   w_close = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_clr = (r_state != S_RUN) | w_close;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    erm_lane #(
      .CNT_WIDTH  (CNT_WIDTH),
      .SYNC_STAGES(SYNC_STAGES),
      .BOTH       (BOTH_EDGES[c])
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .i_sig     (in_sig[c]),
      .i_clr     (w_clr),
      .o_next_cnt(w_next_cnt[c]),
      .o_next_ovf(w_next_ovf[c])
    );
  end

  always_comb begin
    w_rd = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (rd_ch == RD_W'(c)) w_rd = r_result[c];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gate   <= '0;
      r_result <= '0;
      r_ovf    <= '0;
      r_rd     <= '0;
      r_valid  <= 1'b0;
      r_win    <= '0;
    end else begin
      r_valid <= w_close;
      r_rd    <= w_rd;
      if ((r_state == S_ARM) || w_close) r_gate <= w_gate_ld - 1'b1;
      else if (r_state == S_RUN)         r_gate <= r_gate - 1'b1;
      if (w_start)      r_win <= '0;
      else if (w_close) r_win <= r_win + 1'b1;
      if (w_close) begin
        r_result <= w_next_cnt;
        r_ovf    <= w_next_ovf;
      end
    end
  end

  assign rd_data = r_rd;
  assign ovf     = r_ovf;
  assign valid   = r_valid;
  assign win_cnt = r_win;
  assign busy    = (r_state != S_IDLE);
endmodule

// File: tb/tb_event_rate_meter.sv
// Scoreboard bench for event_rate_meter: a wide-counter instance and a 4-bit
// saturating instance share clock, reset, gate length and inputs.

module tb_event_rate_meter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, en_s = 1'b0;
  logic [31:0] gate_len = '0;
  logic [3:0]  in_sig;
  logic [2:0]  rd_ch = '0, rd_ch_s = 3'd3;
  logic [31:0] rd_data;
  logic [3:0]  rd_data_s;
  logic [3:0]  ovf, ovf_s;
  logic        valid, valid_s, busy, busy_s;
  logic [15:0] win_cnt, win_s;

  int checks = 0, errors = 0;
  int cyc = 0;
  bit sq_on = 1'b1, m1 = 1'b0, m3 = 1'b0, tog3 = 1'b0;

  typedef struct {logic [31:0] data; logic [3:0] ovf; logic [15:0] win;} exp_t;
  exp_t q_m[$], q_s[$];

  // ch0/ch1 square wave of period 4, ch2 toggles every cycle, ch3 manual or toggling
  assign in_sig = {tog3 ? cyc[0] : m3, cyc[0], sq_on ? cyc[1] : m1, sq_on & cyc[1]};

  always #5 clk = ~clk;

  event_rate_meter #(.CHANNELS(4), .CNT_WIDTH(32), .REF_HZ(1000), .PERIOD_MS(10),
                     .GATE_W(32), .SYNC_STAGES(2), .BOTH_EDGES(4'b0010)) u_dut (
    .clk(clk), .rst(rst), .en(en), .gate_len(gate_len), .in_sig(in_sig), .rd_ch(rd_ch),
    .rd_data(rd_data), .ovf(ovf), .valid(valid), .win_cnt(win_cnt), .busy(busy));

  event_rate_meter #(.CHANNELS(4), .CNT_WIDTH(4), .REF_HZ(1000), .PERIOD_MS(10),
                     .GATE_W(32), .SYNC_STAGES(2), .BOTH_EDGES(4'b0010)) u_sat (
    .clk(clk), .rst(rst), .en(en_s), .gate_len(gate_len), .in_sig(in_sig), .rd_ch(rd_ch_s),
    .rd_data(rd_data_s), .ovf(ovf_s), .valid(valid_s), .win_cnt(win_s), .busy(busy_s));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_valid(input bit s, input int maxc, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(s ? valid_s : valid) && n < maxc);
    if (!(s ? valid_s : valid)) begin
      checks++;
      errors++;
      $display("FAIL wait_valid_%0d: no valid within %0d cycles", s, maxc);
    end
  endtask

  // Monitor: on each valid pop the expectation, check ovf/win_cnt now and rd_data a cycle later.
  initial begin
    exp_t em, es;
    bit pm, ps;
    pm = 1'b0;
    ps = 1'b0;
    forever begin
      @(negedge clk);
      if (pm) begin chk("m_rd_data", rd_data, em.data); pm = 1'b0; end
      if (ps) begin chk("s_rd_data", 32'(rd_data_s), es.data); ps = 1'b0; end
      if (!rst && valid) begin
        if (q_m.size() == 0) begin
          checks++; errors++;
          $display("FAIL m_valid: unexpected valid at win_cnt=%0d, expected none", win_cnt);
        end else begin
          em = q_m.pop_front();
          chk("m_ovf", 32'(ovf), 32'(em.ovf));
          chk("m_win_cnt", 32'(win_cnt), 32'(em.win));
          pm = 1'b1;
        end
      end
      if (!rst && valid_s) begin
        if (q_s.size() == 0) begin
          checks++; errors++;
          $display("FAIL s_valid: unexpected valid at win_cnt=%0d, expected none", win_s);
        end else begin
          es = q_s.pop_front();
          chk("s_ovf", 32'(ovf_s), 32'(es.ovf));
          chk("s_win_cnt", 32'(win_s), 32'(es.win));
          ps = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) tick();
    chk("rst_rd_data", rd_data, 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_win_cnt", 32'(win_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    repeat (5) tick();

    // Rate and edge mode: 100-cycle window, square wave period 4 on ch0 (rising) and ch1 (both)
    gate_len = 100;
    rd_ch = 0;
    q_m.push_back('{32'd25, 4'd0, 16'd1});
    q_m.push_back('{32'd50, 4'd0, 16'd2});
    en = 1'b1;
    wait_valid(0, 200, n);
    chk("p1_first_latency", n, 102);
    tick();
    rd_ch = 1;
    wait_valid(0, 200, n);
    chk("p1_period", n, 99);

    // Abort mid-window: no valid, results persist, busy drops
    repeat (5) tick();
    en = 1'b0;
    tick();
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rd_data", rd_data, 50);
    repeat (30) tick();
    chk("abort_rd_hold", rd_data, 50);
    chk("abort_win_hold", 32'(win_cnt), 2);

    // Default gate, then override mid-window applies to the following window
    rd_ch = 2;
    gate_len = 0;
    q_m.push_back('{32'd5, 4'd0, 16'd1});
    q_m.push_back('{32'd5, 4'd0, 16'd2});
    q_m.push_back('{32'd5, 4'd0, 16'd3});
    q_m.push_back('{32'd10, 4'd0, 16'd4});
    en = 1'b1;
    wait_valid(0, 50, n);
    chk("p2_first_latency", n, 12);
    wait_valid(0, 50, n);
    chk("p2_def_gap", n, 10);
    gate_len = 20;
    wait_valid(0, 50, n);
    chk("p2_gap_before_override", n, 10);
    wait_valid(0, 50, n);
    chk("p2_override_gap", n, 20);
    en = 1'b0;
    repeat (10) tick();

    // Boundary: ch1 rise detected on the closing cycle, fall detected on the first new cycle
    sq_on = 1'b0;
    rd_ch = 1;
    repeat (10) tick();
    gate_len = 10;
    q_m.push_back('{32'd1, 4'd0, 16'd1});
    q_m.push_back('{32'd1, 4'd0, 16'd2});
    en = 1'b1;
    repeat (9) tick();
    m1 = 1'b1;
    tick();
    m1 = 1'b0;
    wait_valid(0, 20, n);
    chk("p4_valid_at", n, 2);
    wait_valid(0, 20, n);
    chk("p4_gap", n, 10);
    en = 1'b0;
    tick();
    rd_ch = 5;
    tick(); tick();
    chk("rd_ch_out_of_range", rd_data, 0);
    rd_ch = 1;
    tick(); tick();
    chk("rd_ch_back", rd_data, 1);

    // Saturation on the 4-bit instance: 50 edges saturate, then a 10-cycle window of 5 edges
    tog3 = 1'b1;
    repeat (10) tick();
    gate_len = 100;
    q_s.push_back('{32'd15, 4'b1100, 16'd1});
    q_s.push_back('{32'd5, 4'b0000, 16'd2});
    q_s.push_back('{32'd15, 4'b1100, 16'd3});
    en_s = 1'b1;
    repeat (5) tick();
    gate_len = 10;
    wait_valid(1, 200, n);
    gate_len = 100;
    wait_valid(1, 50, n);
    chk("p3_short_gap", n, 10);
    wait_valid(1, 200, n);
    chk("p3_long_gap", n, 100);
    en_s = 1'b0;
    repeat (5) tick();
    chk("p3_ovf_hold", 32'(ovf_s), 32'b1100);
    chk("p3_rd_hold", 32'(rd_data_s), 15);

    // Reset mid-window returns everything to zero; en held high re-arms on first clock
    rd_ch = 2;
    gate_len = 10;
    q_m.push_back('{32'd5, 4'd0, 16'd1});
    en = 1'b1;
    wait_valid(0, 50, n);
    chk("p5_latency", n, 12);
    repeat (3) tick();
    chk("p5_pre_win", 32'(win_cnt), 1);
    chk("p5_pre_busy", 32'(busy), 1);
    chk("p5_pre_rd", rd_data, 5);
    rst = 1'b1;
    #1;
    chk("p5_rst_rd", rd_data, 0);
    chk("p5_rst_win", 32'(win_cnt), 0);
    chk("p5_rst_busy", 32'(busy), 0);
    chk("p5_rst_valid", 32'(valid), 0);
    chk("p5_rst_ovf_s", 32'(ovf_s), 0);
    chk("p5_rst_rd_s", 32'(rd_data_s), 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("p5_rearm_busy", 32'(busy), 1);
    en = 1'b0;
    repeat (5) tick();
    chk("p5_idle_busy", 32'(busy), 0);

    chk("m_queue_empty", q_m.size(), 0);
    chk("s_queue_empty", q_s.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
